calc2_port_issuer: RTL and testbench
====================================

# calc2_port_issuer

Upstream request issuer and response reorderer for one calc2 port. Accepts whole operations (command plus two operands) over a valid/ready handshake, serialises each into the calc2 two-cycle request protocol with an allocated 2-bit tag, and captures tagged responses. Results are returned in issue order over a second valid/ready handshake. One instance sits in front of each calc2 port: reqN_* inputs are driven by this block and out_*N outputs are consumed by it.

## Interface
- DATA_W, 32, operand/result width; must match calc2 data width.
- c_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_valid  in  1  operation offered.
- op_ready  out  1  operation accepted when op_valid && op_ready at a rising edge.
- op_cmd  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others forwarded unchanged).
- op_a  in  DATA_W  operand 1.
- op_b  in  DATA_W  operand 2.
- req_cmd_out  out  4  to calc2 reqN_cmd_in.
- req_data_out  out  DATA_W  to calc2 reqN_data_in.
- req_tag_out  out  2  to calc2 reqN_tag_in.
- resp_in  in  2  from calc2 out_respN; 0 = no response.
- resp_data_in  in  DATA_W  from calc2 out_dataN.
- resp_tag_in  in  2  from calc2 out_tagN.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_status  out  2  calc2 response code, or 2'b11 on timeout.
- res_data  out  DATA_W  result data.
- res_cmd  out  4  command echoed from the issue.
- res_tag  out  2  tag used.
- outstanding  out  3  tags allocated and not yet delivered, 0..4.
- err_spurious  out  1  sticky; response received for a tag not awaiting one.

## Operation
- Reset values: all outputs 0 except op_ready; op_ready 0 while reset is asserted, 1 in the first cycle after release. Free vector all-free; order FIFO empty; err_spurious 0.
- Issue FSM: IDLE -> SEND_A -> SEND_B -> IDLE.
  - IDLE: op_ready = 1 iff at least one tag is free. Accept allocates the lowest-numbered free tag, pushes the tag onto a 4-deep order FIFO, and latches cmd, a and b.
  - SEND_A: drives req_cmd_out = cmd, req_data_out = a, req_tag_out = tag.
  - SEND_B: drives req_cmd_out = 0, req_data_out = b, req_tag_out = 0.
  - In IDLE all req_* outputs are 0.
- Response capture: on any edge with resp_in != 0:
  - If resp_tag_in is allocated and its slot is not yet filled: store status, data and a filled flag in slot[tag].
  - Otherwise: drop the response and set err_spurious.
- Delivery:
  - res_valid = slot[head of order FIFO].filled.
  - res_status, res_data, res_cmd and res_tag come from the head slot, and are held stable while res_valid && !res_ready.
  - On handshake: pop the FIFO, clear the slot, free the tag. The tag can be reallocated from the next cycle.
- Simultaneous events:
  - Capture and delivery in the same cycle on different tags are both honoured.
  - Accept and free in the same cycle are both honoured. outstanding nets +1 -1 = 0.
- Maximum 4 outstanding. With all tags allocated, op_ready = 0 until a delivery completes.
- All arithmetic is performed by calc2; this block never modifies data.

## Timing
- Accept at edge k. req_* carries cmd/a/tag in cycle k+1 and 0/b/0 in cycle k+2. IDLE with op_ready is re-evaluated in cycle k+3. The maximum issue rate is one operation per 3 cycles.
- Response captured at edge j. If its tag is at the head, res_valid = 1 in cycle j+1. Capture-to-result latency is 1 cycle.
- All outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- Reset asserted mid-operation clears everything immediately: the in-flight request is abandoned and req_* goes to 0. Responses arriving afterwards count as spurious.

## Configuration
- CALC2_ISSUER_TIMEOUT_EN defined:
  - Each allocated, unfilled tag has an 8-bit age counter that increments every cycle from SEND_A onward.
  - When the counter reaches 255, the slot is filled with status 2'b11 and data 0.
  - A late response for that tag is then spurious.
- CALC2_ISSUER_TIMEOUT_EN undefined: no counters; a tag waits indefinitely and status 2'b11 is never produced.

## Test plan
- Reset: assert reset for 3 cycles mid-issue -> all outputs 0 during reset, req_* 0 immediately, op_ready 1 one cycle after release, outstanding 0.
- Single add:
  - Stimulus: op_cmd=1, a=5, b=7.
  - Required request: req_* = 1/5/0, then 0/7/0.
  - Drive resp_in=01, data=12, tag=0 -> next cycle res_valid=1, status=01, data=12, cmd=1, tag=0.
- Reorder:
  - Stimulus: issue four ops, expecting tags 0,1,2,3; op_ready=0 after the fourth and outstanding=4.
  - Responses arrive in tag order 3,1,0,2 -> deliveries occur in tag order 0,1,2,3 with correct data.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles with a result pending.
  - Required response: all res_* outputs stable throughout; a single delivery once res_ready=1.
- Spurious: resp_in=01 with tag 2 while tag 2 is free -> err_spurious=1 and stays set; no res_valid.
- Timeout (macro defined): issue sub 3-9 and send no response -> status 2'b11, data 0 delivered 255 cycles after SEND_A; a later tag-0 response sets err_spurious.

Source files
------------

// File: rtl/calc2_port_issuer.sv
// calc2 port issuer: serialises operations into tagged two-cycle requests, returns results in issue order.
// Optional response timeout enabled by defining CALC2_ISSUER_TIMEOUT_EN.
module calc2_port_issuer #(
  parameter int DATA_W = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_cmd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  output logic [1:0]        req_tag_out,
  input  logic [1:0]        resp_in,
  input  logic [DATA_W-1:0] resp_data_in,
  input  logic [1:0]        resp_tag_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_status,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_cmd,
  output logic [1:0]        res_tag,
  output logic [2:0]        outstanding,
  output logic              err_spurious
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND_A = 2'd1;
  localparam logic [1:0] SEND_B = 2'd2;

  logic [1:0]        state;
  logic [3:0]        alloc;
  logic [3:0]        filled;
  logic [1:0]        st_q  [4];
  logic [DATA_W-1:0] dat_q [4];
  logic [3:0]        cmd_s [4];
  logic [1:0]        fifo  [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        cnt;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        tag_q;
  logic              err_q;
  logic [1:0]        new_tag;
  logic [1:0]        head;
  logic              accept;
  logic              deliver;
  logic              cap_hit;
`ifdef CALC2_ISSUER_TIMEOUT_EN
  logic [7:0]        age [4];
`endif

  always_comb begin
    new_tag = 2'd0;
    if (!alloc[0])      new_tag = 2'd0;
    else if (!alloc[1]) new_tag = 2'd1;
    else if (!alloc[2]) new_tag = 2'd2;
    else                new_tag = 2'd3;
  end

  assign head     = fifo[rd_ptr];
  assign op_ready = !reset && (state == IDLE) && !(&alloc);
  assign accept   = op_valid && op_ready;
  assign res_valid = (cnt != 3'd0) && filled[head];
  assign deliver  = res_valid && res_ready;
  assign cap_hit  = (resp_in != 2'd0) && alloc[resp_tag_in]
                    && !filled[resp_tag_in];

  // Head slot contents cannot change while filled, so res_* hold under stall.
  assign res_status   = st_q[head];
  assign res_data     = dat_q[head];
  assign res_cmd      = cmd_s[head];
  assign res_tag      = head;
  assign outstanding  = cnt;
  assign err_spurious = err_q;

  always_comb begin
    req_cmd_out  = '0;
    req_data_out = '0;
    req_tag_out  = '0;
    case (state)
      SEND_A: begin
        req_cmd_out  = cmd_q;
        req_data_out = a_q;
        req_tag_out  = tag_q;
      end
      SEND_B: req_data_out = b_q;
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      alloc  <= '0;
      filled <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      cmd_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= '0;
        dat_q[i] <= '0;
        cmd_s[i] <= '0;
        fifo[i]  <= '0;
`ifdef CALC2_ISSUER_TIMEOUT_EN
        age[i]   <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE:    if (accept) state <= SEND_A;
        SEND_A:  state <= SEND_B;
        default: state <= IDLE;
      endcase

      if (accept) begin
        alloc[new_tag] <= 1'b1;
        cmd_s[new_tag] <= op_cmd;
        fifo[wr_ptr]   <= new_tag;
        wr_ptr         <= wr_ptr + 2'd1;
        tag_q          <= new_tag;
        cmd_q          <= op_cmd;
        a_q            <= op_a;
        b_q            <= op_b;
      end

      // A newly accepted tag is free, so it never collides with the head.
      if (deliver) begin
        alloc[head]  <= 1'b0;
        filled[head] <= 1'b0;
        rd_ptr       <= rd_ptr + 2'd1;
      end

      cnt <= cnt + 3'(accept) - 3'(deliver);

      if (resp_in != 2'd0) begin
        if (cap_hit) begin
          filled[resp_tag_in] <= 1'b1;
          st_q[resp_tag_in]   <= resp_in;
          dat_q[resp_tag_in]  <= resp_data_in;
        end else begin
          err_q <= 1'b1;
        end
      end

`ifdef CALC2_ISSUER_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
        if (accept && (new_tag == 2'(i))) begin
          age[i] <= '0;
        end else if (alloc[i] && !filled[i]) begin
          age[i] <= age[i] + 8'd1;
          if ((age[i] == 8'd254)
              && !(cap_hit && (resp_tag_in == 2'(i)))) begin
            filled[i] <= 1'b1;
            st_q[i]   <= 2'b11;
            dat_q[i]  <= '0;
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_calc2_port_issuer.sv
// Directed bench for calc2_port_issuer: reset, issue, reorder, stall, spurious.
// Timeout vectors run only when CALC2_ISSUER_TIMEOUT_EN is defined.
module tb_calc2_port_issuer;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  resp_in;
  logic [31:0] resp_data_in;
  logic [1:0]  resp_tag_in;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_status;
  logic [31:0] res_data;
  logic [3:0]  res_cmd;
  logic [1:0]  res_tag;
  logic [2:0]  outstanding;
  logic        err_spurious;

  int n_chk = 0;
  int n_fail = 0;
  int rord [4] = '{3, 1, 0, 2};

  always #5 c_clk = ~c_clk;

  calc2_port_issuer #(.DATA_W(32)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out),
    .resp_in(resp_in), .resp_data_in(resp_data_in),
    .resp_tag_in(resp_tag_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_status(res_status), .res_data(res_data),
    .res_cmd(res_cmd), .res_tag(res_tag),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  // Returns in the SEND_A cycle.
  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    op_valid = 1'b1;
    op_cmd   = c;
    op_a     = a;
    op_b     = b;
    step();
    op_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] s, input logic [31:0] d,
                         input logic [1:0] t);
    resp_in      = s;
    resp_data_in = d;
    resp_tag_in  = t;
    step();
    resp_in = 2'd0;
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op_cmd = '0; op_a = '0; op_b = '0;
    resp_in = '0; resp_data_in = '0; resp_tag_in = '0;
    res_ready = 1'b0;
    step(); step();
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_req", {req_cmd_out, req_data_out, req_tag_out}, 0);
    check("rst_err", err_spurious, 0);
    reset = 1'b0;
    #1;
    check("rel_op_ready", op_ready, 1);

    // Reset while a request is on the wire
    issue(4'd1, 32'd3, 32'd4);
    check("pre_rst_cmd", req_cmd_out, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", {req_cmd_out, req_data_out, req_tag_out}, 0);
    check("mid_rst_ready", op_ready, 0);
    check("mid_rst_outst", outstanding, 0);
    step(); step(); step();
    check("hold_rst_res", {res_valid, res_status, res_data}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", op_ready, 1);
    check("post_rst_outst", outstanding, 0);

    // Single add
    issue(4'd1, 32'd5, 32'd7);
    check("add_req_a", {req_cmd_out, req_data_out, req_tag_out},
          {4'd1, 32'd5, 2'd0});
    check("add_ready_busy", op_ready, 0);
    step();
    check("add_req_b", {req_cmd_out, req_data_out, req_tag_out},
          {4'd0, 32'd7, 2'd0});
    step();
    check("add_req_idle", {req_cmd_out, req_data_out, req_tag_out}, 0);
    check("add_no_res", res_valid, 0);
    respond(2'b01, 32'd12, 2'd0);
    check("add_res_valid", res_valid, 1);
    check("add_res", {res_status, res_data, res_cmd, res_tag},
          {2'b01, 32'd12, 4'd1, 2'd0});
    check("add_outst", outstanding, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("add_done", {res_valid, outstanding}, 0);

    // Reorder: four in flight, responses 3,1,0,2
    for (int i = 0; i < 4; i++) begin
      issue(4'd1, 32'(10 * i), 32'(i));
      check($sformatf("ro_tag%0d", i), req_tag_out, i);
      step(); step();
    end
    check("ro_full_ready", op_ready, 0);
    check("ro_full_outst", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      respond(2'b01, 32'(100 + rord[i]), 2'(rord[i]));
      check($sformatf("ro_valid%0d", i), res_valid, (i >= 2) ? 1 : 0);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ro_out%0d", i), {res_valid, res_tag, res_data},
            {1'b1, 2'(i), 32'(100 + i)});
      step();
    end
    res_ready = 1'b0;
    check("ro_empty", {res_valid, outstanding}, 0);
    check("ro_ready_back", op_ready, 1);
    check("ro_no_err", err_spurious, 0);

    // Backpressure
    issue(4'd2, 32'd20, 32'd3);
    check("bp_tag", req_tag_out, 0);
    step(); step();
    respond(2'b10, 32'd17, 2'd0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i),
            {res_valid, res_status, res_data, res_cmd, res_tag},
            {1'b1, 2'b10, 32'd17, 4'd2, 2'd0});
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp_once", {res_valid, outstanding}, 0);
    step();
    check("bp_still_none", res_valid, 0);

`ifdef CALC2_ISSUER_TIMEOUT_EN
    // Timeout: sub 3-9, no response
    issue(4'd2, 32'd3, 32'd9);
    for (int i = 0; i < 254; i++) step();
    check("to_not_yet", res_valid, 0);
    step();
    check("to_res", {res_valid, res_status, res_data, res_cmd},
          {1'b1, 2'b11, 32'd0, 4'd2});
    respond(2'b01, 32'd6, 2'd0);
    check("to_late_err", err_spurious, 1);
    check("to_data_kept", res_data, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("to_done", outstanding, 0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("to_err_cleared", err_spurious, 0);
`endif

    // Spurious on free tag 2
    respond(2'b01, 32'd55, 2'd2);
    check("sp_err", err_spurious, 1);
    check("sp_no_res", res_valid, 0);
    step(); step(); step();
    check("sp_sticky", err_spurious, 1);
    check("sp_outst", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
